// File: rtl/alsu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alsu_cmd_sequencer
// Brief    : Command FIFO, single-issue ALSU driver and tagged result collector.
// Revision : 1.0 - initial release
// ============================================================================
module alsu_cmd_sequencer #(
    parameter int DEPTH        = 4,
    parameter int ALSU_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    // command intake
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_cmd,
    // ALSU drive
    output logic [2:0]  alsu_opcode,
    output logic [2:0]  alsu_A,
    output logic [2:0]  alsu_B,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_red_op_A,
    output logic        alsu_red_op_B,
    output logic        alsu_bypass_A,
    output logic        alsu_bypass_B,
    output logic        alsu_direction,
    // ALSU observation
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds,
    // result return
    output logic        res_valid,
    input  logic        res_ready,
    output logic [5:0]  res_data,
    output logic        res_err,
    output logic [3:0]  res_tag
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_LAT_W = (ALSU_LATENCY > 0) ? $clog2(ALSU_LATENCY + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_LAT_W-1:0] c_LAT  = c_LAT_W'(ALSU_LATENCY);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    logic [15:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_issue;
    logic        w_capture;
    logic [15:0] w_head;

    assign w_full   = (r_count == c_FULL);
    assign w_empty  = (r_count == '0);
    // Ready is forced low during reset so nothing is accepted while state is cleared.
    assign in_ready = ~rst & ~w_full;
    assign w_push   = in_valid & in_ready;
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_cmd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_LAT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (!w_empty)          w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (r_cnt == c_LAT)    w_state_nxt = c_ST_RESP;
            c_ST_RESP: if (res_ready)         w_state_nxt = c_ST_IDLE;
            default:                          w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue   = 1'b0;
        w_capture = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            c_ST_IDLE: w_issue   = ~w_empty;
            c_ST_WAIT: w_capture = (r_cnt == c_LAT);
            c_ST_RESP: res_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Drive, tag and result registers
    // ------------------------------------------------------------------------
    logic [15:0] r_cmd;
    logic [3:0]  r_tag_cnt;
    logic [3:0]  r_inflight_tag;
    logic [5:0]  r_res_data;
    logic        r_res_err;
    logic [3:0]  r_res_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd          <= '0;
            r_cnt          <= '0;
            r_tag_cnt      <= '0;
            r_inflight_tag <= '0;
            r_res_data     <= '0;
            r_res_err      <= 1'b0;
            r_res_tag      <= '0;
        end else begin
            if (w_issue) begin
                r_cmd          <= w_head;
                r_cnt          <= '0;
                r_inflight_tag <= r_tag_cnt;
                r_tag_cnt      <= r_tag_cnt + 4'd1;
            end else if (r_state == c_ST_WAIT && !w_capture) begin
                r_cnt <= r_cnt + c_LAT_W'(1);
            end
            if (w_capture) begin
                r_res_data <= alsu_out;
                r_res_err  <= |alsu_leds;
                r_res_tag  <= r_inflight_tag;
            end
        end
    end

    // The held command keeps the ALSU re-evaluating it between issues.
    assign alsu_opcode    = r_cmd[15:13];
    assign alsu_A         = r_cmd[12:10];
    assign alsu_B         = r_cmd[9:7];
    assign alsu_cin       = r_cmd[6];
    assign alsu_serial_in = r_cmd[5];
    assign alsu_red_op_A  = r_cmd[4];
    assign alsu_red_op_B  = r_cmd[3];
    assign alsu_bypass_A  = r_cmd[2];
    assign alsu_bypass_B  = r_cmd[1];
    assign alsu_direction = r_cmd[0];

    assign res_data = r_res_data;
    assign res_err  = r_res_err;
    assign res_tag  = r_res_tag;

endmodule
`default_nettype wire

// File: tb/tb_alsu_cmd_sequencer.sv
`default_nettype none
// Bench for alsu_cmd_sequencer: a small ALSU stand-in plus a queue-based
// reference model compared against the DUT on every falling edge.
module tb_alsu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_cmd = '0;
    logic [2:0]  alsu_opcode, alsu_A, alsu_B;
    logic        alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
    logic        alsu_bypass_A, alsu_bypass_B, alsu_direction;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [5:0]  res_data;
    logic        res_err;
    logic [3:0]  res_tag;
    logic [15:0] drv;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alsu_cmd_sequencer #(.DEPTH(DEPTH), .ALSU_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
        .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_direction(alsu_direction),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .res_tag(res_tag)
    );

    assign drv = {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in,
                  alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
                  alsu_direction};

    // ALSU behaviour as a pure function of a packed command: {err, out}.
    function automatic logic [6:0] alsu_f(input logic [15:0] c);
        logic [2:0] op, a, b;
        logic [5:0] ab, o;
        op = c[15:13]; a = c[12:10]; b = c[9:7]; ab = {a, b};
        o  = '0;
        if (op > 3'd5 || ((c[4] || c[3]) && op > 3'd1)) return {1'b1, 6'd0};
        if (c[2]) return {1'b0, 3'd0, a};
        if (c[1]) return {1'b0, 3'd0, b};
        case (op)
            3'd0: o = c[4] ? {5'd0, &a} : c[3] ? {5'd0, &b} : {3'd0, a & b};
            3'd1: o = c[4] ? {5'd0, ^a} : c[3] ? {5'd0, ^b} : {3'd0, a ^ b};
            3'd2: o = {3'd0, a} + {3'd0, b} + {5'd0, c[6]};
            3'd3: o = {3'd0, a} * {3'd0, b};
            3'd4: o = c[0] ? {ab[4:0], c[5]} : {c[5], ab[5:1]};
            default: o = c[0] ? {ab[4:0], ab[5]} : {ab[0], ab[5:1]};
        endcase
        return {1'b0, o};
    endfunction

    // ALSU stand-in: input register stage then output register stage.
    logic [15:0] alsu_in_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alsu_in_q <= '0;
            alsu_out  <= '0;
            alsu_leds <= '0;
        end else begin
            alsu_in_q <= drv;
            alsu_out  <= alsu_f(alsu_in_q)[5:0];
            alsu_leds <= alsu_f(alsu_in_q)[6] ? 16'hFFFF : 16'h0000;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of waiting commands, one in flight whose result
    // becomes visible LAT+1 edges after issue and leaves on a consumer handshake.
    logic [15:0] fq[$];
    logic [15:0] m_drv      = '0;
    logic        m_busy     = 1'b0;
    logic        m_resp     = 1'b0;
    int          m_issue_n  = 0;
    int          edge_n     = 0;
    logic [3:0]  m_tag_next = '0;
    logic [3:0]  m_tag_cur  = '0;
    logic [5:0]  m_data     = '0;
    logic        m_err      = 1'b0;
    logic [3:0]  m_rtag     = '0;
    bit          m_acc;
    logic [6:0]  m_r;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            fq.delete();
            m_drv = '0; m_busy = 1'b0; m_resp = 1'b0; m_tag_next = '0;
            m_data = '0; m_err = 1'b0; m_rtag = '0;
        end else begin
            edge_n++;
            m_acc = in_valid && (fq.size() < DEPTH);
            if (!m_busy) begin
                if (fq.size() > 0) begin
                    m_drv      = fq.pop_front();
                    m_busy     = 1'b1;
                    m_issue_n  = edge_n;
                    m_tag_cur  = m_tag_next;
                    m_tag_next = m_tag_next + 4'd1;
                end
            end else if (!m_resp) begin
                if (edge_n == m_issue_n + LAT + 1) begin
                    m_r    = alsu_f(m_drv);
                    m_data = m_r[5:0];
                    m_err  = m_r[6];
                    m_rtag = m_tag_cur;
                    m_resp = 1'b1;
                end
            end else if (res_ready) begin
                m_resp = 1'b0;
                m_busy = 1'b0;
            end
            if (m_acc) fq.push_back(in_cmd);
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("in_ready",   {31'd0, in_ready},  {31'd0, (!rst && fq.size() < DEPTH)});
        chk("res_valid",  {31'd0, res_valid}, {31'd0, m_resp});
        chk("res_data",   {26'd0, res_data},  {26'd0, m_data});
        chk("res_err",    {31'd0, res_err},   {31'd0, m_err});
        chk("res_tag",    {28'd0, res_tag},   {28'd0, m_rtag});
        chk("alsu_drive", {16'd0, drv},       {16'd0, m_drv});
    end

    task automatic push(input logic [15:0] c);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_cmd   = c;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    // Returns at the falling edge where res_valid is first seen; k counts
    // falling edges after the accepting edge.
    task automatic wait_res(output int k);
        k = 0;
        @(negedge clk);
        while (!res_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!res_valid) chk("res_timeout", 0, 1);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    logic [15:0] bp [6];
    bit          bp_acc [6];
    int          k, n_acc;

    initial begin
        // Model pins
        chk("model_xor", {25'd0, alsu_f(16'h3580)}, 32'h06);
        chk("model_add", {25'd0, alsu_f(16'h5FC0)}, 32'h0F);
        chk("model_inv", {25'd0, alsu_f(16'hC000)}, 32'h40);

        // Reset with traffic present
        in_valid = 1'b1;
        in_cmd   = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  0);
        chk("rst_res_valid", {31'd0, res_valid}, 0);
        chk("rst_drive",     {16'd0, drv},       0);
        chk("rst_res",       {21'd0, res_data, res_err, res_tag}, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #2;

        // XOR, latency from accept
        res_ready = 1'b1;
        push(16'h3580);
        wait_res(k);
        chk("xor_latency", k, 4);
        chk("xor_data", {26'd0, res_data}, 6);
        chk("xor_err",  {31'd0, res_err},  0);
        chk("xor_tag",  {28'd0, res_tag},  0);
        @(posedge clk); #2;

        // Add with carry
        push(16'h5FC0);
        wait_res(k);
        chk("add_data", {26'd0, res_data}, 15);
        chk("add_err",  {31'd0, res_err},  0);
        chk("add_tag",  {28'd0, res_tag},  1);
        @(posedge clk); #2;

        // Backpressure and full FIFO
        do_reset(2);
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) bp[i] = {3'(i % 4), 13'($urandom)} & ~16'h0018;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_cmd   = bp[i];
            @(negedge clk);
            bp_acc[i] = in_ready;
            if (in_ready) n_acc++;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        chk("bp_accepted", n_acc, 5);
        chk("bp_sixth_ready", {31'd0, bp_acc[5]}, 0);
        repeat (5) @(posedge clk);
        #2;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_res(k);
            chk("bp_tag",  {28'd0, res_tag},  i);
            chk("bp_data", {26'd0, res_data}, {26'd0, alsu_f(bp[i])[5:0]});
            @(posedge clk); #2;
        end

        // Invalid opcode
        push(16'hC000);
        wait_res(k);
        chk("inv_data", {26'd0, res_data}, 0);
        chk("inv_err",  {31'd0, res_err},  1);
        @(posedge clk); #2;
        repeat (2) @(posedge clk);
        #2;

        // Reset one cycle after issue, two commands still queued
        push(16'h2A81);
        push(16'h4B42);
        push(16'h6C03);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready},  1);
        chk("midrst_valid",    {31'd0, res_valid}, 0);
        @(posedge clk); #2;
        push(16'h3580);
        wait_res(k);
        chk("midrst_tag",  {28'd0, res_tag},  0);
        chk("midrst_data", {26'd0, res_data}, 6);
        @(posedge clk); #2;

        // Randomized traffic with occasional reset pulses
        for (int i = 0; i < 700; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_cmd    = 16'($urandom);
            res_ready = (i % 100 < 30) ? ($urandom_range(0, 7) == 0)
                                       : ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            @(posedge clk); #2;
        end
        in_valid  = 1'b0;
        rst       = 1'b0;
        res_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("drain_idle", {31'd0, res_valid}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alsu_cmd_sequencer.md
# alsu_cmd_sequencer

Command front-end and result collector for the ALSU. It accepts packed 16-bit ALSU commands over a valid/ready handshake and buffers them in a small FIFO. It drives one command at a time onto the ALSU input ports, samples `out`/`leds` once the ALSU's two-register latency has elapsed, and returns the tagged result over a second valid/ready handshake. It sits directly upstream of the ALSU instance and owns every one of its inputs, except `clk` and `rst`.

## Interface
- `DEPTH`, default 4: command FIFO depth; must be a power of 2, at least 2.
- `ALSU_LATENCY`, default 2: ALSU register stages from input ports to `out`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset; also fanned to the ALSU.
- `in_valid` in 1: command word present.
- `in_ready` out 1: FIFO can accept; equals !full; 0 while `rst`=1.
- `in_cmd` in 16: packed command, one field per bit range:
  - [15:13] opcode
  - [12:10] A
  - [9:7] B
  - [6] cin
  - [5] serial_in
  - [4] red_op_A
  - [3] red_op_B
  - [2] bypass_A
  - [1] bypass_B
  - [0] direction
- `alsu_opcode`, `alsu_A`, `alsu_B` out 3 each: registered drives to the ALSU.
- `alsu_cin`, `alsu_serial_in`, `alsu_red_op_A`, `alsu_red_op_B`, `alsu_bypass_A`, `alsu_bypass_B`, `alsu_direction` out 1 each: registered drives to the ALSU.
- `alsu_out` in 6: ALSU `out`.
- `alsu_leds` in 16: ALSU `leds`.
- `res_valid` out 1: result held for the consumer.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 6: captured `alsu_out`.
- `res_err` out 1: captured `|alsu_leds`; 1 means the ALSU flagged an invalid command.
- `res_tag` out 4: sequence number of the command that produced the result.

## Operation
- **FIFO**
  - Push on `in_valid && in_ready`.
  - Pop only in IDLE when the FIFO is not empty.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - Order is strictly FIFO. Pointers wrap modulo DEPTH. A separate count, 0..DEPTH, distinguishes full from empty.
- **FSM states:** IDLE, WAIT, RESP.
  - **IDLE:** if FIFO not empty, pop the head, load all ALSU drive registers from its fields, latch `tag_cnt` into the in-flight tag, increment `tag_cnt` (4-bit, wraps 15→0), clear `cnt`, go to WAIT. Otherwise stay in IDLE.
  - **WAIT:** `cnt` increments each cycle. At the edge where `cnt == ALSU_LATENCY`, capture `res_data` ← `alsu_out`, `res_err` ← `|alsu_leds`, `res_tag` ← in-flight tag, and go to RESP.
  - **RESP:** `res_valid`=1. `res_data`, `res_err` and `res_tag` are stable until `res_ready`=1 is sampled, then go to IDLE.
- **ALSU drive registers** change only on an IDLE→WAIT transition.
  - Between commands the last command stays applied, so the ALSU keeps re-evaluating it.
  - Chained shift/rotate state across commands is not guaranteed.
- Exactly one command is in flight. The FIFO keeps accepting during WAIT and RESP.
- No arithmetic is performed on the data; fields pass through unmodified.

## Timing
- **Reset values** (immediate on `rst` assertion, independent of `clk`):
  - All ALSU drive outputs = 0.
  - `res_valid`, `res_data`, `res_err`, `res_tag` = 0.
  - `tag_cnt` = 0; FIFO empty; state IDLE.
- Reset mid-operation drops the in-flight command, any unconsumed result and all queued commands.
- **Latency** (E0 = the IDLE→WAIT edge):
  - ALSU samples the drives at E0+1; `out` updates at E0+2; capture occurs at E0+ALSU_LATENCY+1.
  - With an empty FIFO and idle FSM, a command accepted at edge Ea gives `res_valid`=1 after edge Ea+ALSU_LATENCY+2 (Ea+4 by default).
- **Throughput:** one command per ALSU_LATENCY+3 cycles when `res_ready` is held at 1.
- **Full FIFO:** `in_ready`=0. A pop in the same cycle does not raise `in_ready` until the next cycle.
- **Backpressure:** `res_ready`=0 holds RESP indefinitely; no further commands issue.

## Test plan
- **Reset:** `rst`=1 with `in_valid`=1 and `in_cmd`=16'hFFFF for 3 cycles → `in_ready`=0, all outputs 0; after release, `in_ready`=1 on the next cycle.
- **XOR:** push 16'h3580 (opcode 1, A=5, B=3) into an idle block → `res_valid` 4 cycles after accept, `res_data`=6, `res_err`=0, `res_tag`=0.
- **Add with carry** (ALSU `FULL_ADDER`="ON"): push 16'h5FC0 (opcode 2, A=7, B=7, cin=1) → `res_data`=15, `res_err`=0, `res_tag`=1.
- **Backpressure and full:** hold `res_ready`=0 and push 6 commands back-to-back.
  - 5 accepted: 1 in flight plus 4 queued; `in_ready`=0 on the 6th.
  - Release `res_ready` → results return in push order with tags 0..4.
- **Invalid opcode:** push 16'hC000 (opcode 6) → `res_data`=0, `res_err`=1.
- **Reset mid-WAIT:** with 2 commands queued, assert `rst` one cycle after the IDLE→WAIT edge.
  - `res_valid` never rises.
  - After release the FIFO is empty, and the next command returns `res_tag`=0.
